// File: rtl/time_editor.sv
// time_editor: push-button front end for setting the clock time.
// Five raw buttons are synchronized and debounced into one-cycle press
// pulses; a two-state edit FSM walks hour/minute/second and issues a
// single-cycle load strobe carrying the edited time.
module time_editor #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        middle,
    input  logic [10:0] cur_hour,
    input  logic [10:0] cur_minute,
    input  logic [10:0] cur_second,
    output logic [10:0] set_hour,
    output logic [10:0] set_minute,
    output logic [10:0] set_second,
    output logic        load,
    output logic        editing,
    output logic [1:0]  field
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // Button bit positions within the packed vectors below.
    localparam int unsigned B_DOWN   = 0;
    localparam int unsigned B_UP     = 1;
    localparam int unsigned B_RIGHT  = 2;
    localparam int unsigned B_LEFT   = 3;
    localparam int unsigned B_MIDDLE = 4;

    localparam logic [1:0] F_NONE = 2'd0;
    localparam logic [1:0] F_SEC  = 2'd1;
    localparam logic [1:0] F_MIN  = 2'd2;
    localparam logic [1:0] F_HOUR = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_EDIT
    } state_t;

    logic [4:0]         raw;
    logic [4:0]         sync1_q, sync1_d;
    logic [4:0]         sync2_q, sync2_d;
    logic [4:0]         stable_q, stable_d;
    logic [4:0]         stable_prev_q, stable_prev_d;
    logic [4:0]         pulse_q, pulse_d;
    logic [4:0][CW-1:0] db_cnt_q, db_cnt_d;

    state_t      state_q, state_d;
    logic [10:0] set_hour_q, set_hour_d;
    logic [10:0] set_minute_q, set_minute_d;
    logic [10:0] set_second_q, set_second_d;
    logic        load_q, load_d;
    logic        editing_q, editing_d;
    logic [1:0]  field_q, field_d;
    logic [TW-1:0] tmo_q, tmo_d;

    assign raw = {middle, left, right, up, down};

    assign set_hour   = set_hour_q;
    assign set_minute = set_minute_q;
    assign set_second = set_second_q;
    assign load       = load_q;
    assign editing    = editing_q;
    assign field      = field_q;

    function automatic logic [10:0] wrap_inc(input logic [10:0] v, input logic [10:0] max);
        return (v >= max) ? 11'd0 : v + 11'd1;
    endfunction

    function automatic logic [10:0] wrap_dec(input logic [10:0] v, input logic [10:0] max);
        return (v == 11'd0) ? max : v - 11'd1;
    endfunction

    // Synchronizer, debounce counters and rising-edge press detection.
    always_comb begin
        sync1_d       = raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        db_cnt_d      = '0;
        stable_prev_d = stable_q;
        pulse_d       = stable_q & ~stable_prev_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Button path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            pulse_q       <= '0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            pulse_q       <= pulse_d;
            db_cnt_q      <= db_cnt_d;
        end
    end

    // Edit FSM state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            set_hour_q   <= '0;
            set_minute_q <= '0;
            set_second_q <= '0;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
            field_q      <= F_NONE;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            set_hour_q   <= set_hour_d;
            set_minute_q <= set_minute_d;
            set_second_q <= set_second_d;
            load_q       <= load_d;
            editing_q    <= editing_d;
            field_q      <= field_d;
            tmo_q        <= tmo_d;
        end
    end

    // Edit FSM next state: one prioritized action per cycle, idle timeout.
    always_comb begin
        state_d      = state_q;
        set_hour_d   = set_hour_q;
        set_minute_d = set_minute_q;
        set_second_d = set_second_q;
        load_d       = 1'b0;
        editing_d    = editing_q;
        field_d      = field_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (pulse_q[B_MIDDLE]) begin
                    set_hour_d   = (cur_hour   > 11'd23) ? 11'd0 : cur_hour;
                    set_minute_d = (cur_minute > 11'd59) ? 11'd0 : cur_minute;
                    set_second_d = (cur_second > 11'd59) ? 11'd0 : cur_second;
                    field_d      = F_HOUR;
                    editing_d    = 1'b1;
                    state_d      = ST_EDIT;
                end
            end

            ST_EDIT: begin
                if (pulse_q != '0) begin
                    tmo_d = '0;
                    if (pulse_q[B_MIDDLE]) begin
                        load_d    = 1'b1;
                        field_d   = F_NONE;
                        editing_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else if (pulse_q[B_LEFT]) begin
                        field_d = (field_q == F_HOUR) ? F_SEC : field_q + 2'd1;
                    end else if (pulse_q[B_RIGHT]) begin
                        field_d = (field_q == F_SEC) ? F_HOUR : field_q - 2'd1;
                    end else if (pulse_q[B_UP]) begin
                        case (field_q)
                            F_SEC:   set_second_d = wrap_inc(set_second_q, 11'd59);
                            F_MIN:   set_minute_d = wrap_inc(set_minute_q, 11'd59);
                            F_HOUR:  set_hour_d   = wrap_inc(set_hour_q, 11'd23);
                            default: ;
                        endcase
                    end else begin
                        case (field_q)
                            F_SEC:   set_second_d = wrap_dec(set_second_q, 11'd59);
                            F_MIN:   set_minute_d = wrap_dec(set_minute_q, 11'd59);
                            F_HOUR:  set_hour_d   = wrap_dec(set_hour_q, 11'd23);
                            default: ;
                        endcase
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d     = '0;
                    field_d   = F_NONE;
                    editing_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_time_editor.sv
// Testbench for time_editor: table of button presses with expected edit
// state, a scoreboard queue for committed loads, and hand-written sequences
// for press latency, bounce rejection, hold, timeout and mid-edit reset.
module tb_time_editor;

    localparam int unsigned N   = 16;
    localparam int unsigned TMO = 1000;

    localparam logic [4:0] BM = 5'b10000;
    localparam logic [4:0] BL = 5'b01000;
    localparam logic [4:0] BR = 5'b00100;
    localparam logic [4:0] BU = 5'b00010;
    localparam logic [4:0] BD = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
    logic [10:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
    logic [10:0] set_hour, set_minute, set_second;
    logic        load, editing;
    logic [1:0]  field;

    time_editor #(
        .DEBOUNCE_CYCLES(N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .middle    (middle),
        .cur_hour  (cur_hour),
        .cur_minute(cur_minute),
        .cur_second(cur_second),
        .set_hour  (set_hour),
        .set_minute(set_minute),
        .set_second(set_second),
        .load      (load),
        .editing   (editing),
        .field     (field)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  btn;
        logic [10:0] ch, cm, cs;
        logic        exp_ed;
        logic [1:0]  exp_f;
        logic [10:0] eh, em, es;
        logic        commit;
    } vec_t;

    typedef struct packed {
        logic [10:0] h, m, s;
    } tm_t;

    vec_t tbl[17];
    tm_t  sb_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   load_cnt = 0;
    logic prev_load = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, then sample outputs 1 time unit after the edge.
    task automatic tick();
        tm_t e;
        @(posedge clk);
        #1;
        if (load === 1'b1) begin
            chk("load_consecutive", {31'd0, prev_load}, 32'd0);
            load_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_load", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("load_hour", {21'd0, set_hour}, {21'd0, e.h});
                chk("load_minute", {21'd0, set_minute}, {21'd0, e.m});
                chk("load_second", {21'd0, set_second}, {21'd0, e.s});
            end
        end
        prev_load = load;
    endtask

    task automatic drive_btn(input logic [4:0] b);
        {middle, left, right, up, down} = b;
    endtask

    task automatic press(input logic [4:0] b);
        tick();
        drive_btn(b);
        repeat (N + 8) tick();
        drive_btn(5'b0);
        repeat (N + 8) tick();
    endtask

    task automatic chk_state(input string tag, input logic ed, input logic [1:0] f,
                             input logic [10:0] h, input logic [10:0] m, input logic [10:0] s);
        chk({tag, "_editing"}, {31'd0, editing}, {31'd0, ed});
        chk({tag, "_field"}, {30'd0, field}, {30'd0, f});
        chk({tag, "_hour"}, {21'd0, set_hour}, {21'd0, h});
        chk({tag, "_minute"}, {21'd0, set_minute}, {21'd0, m});
        chk({tag, "_second"}, {21'd0, set_second}, {21'd0, s});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        tbl[0]  = '{BU, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd13, 11'd34, 11'd56, 1'b0};
        tbl[1]  = '{BU, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd14, 11'd34, 11'd56, 1'b0};
        tbl[2]  = '{BM, 11'd0, 11'd0, 11'd0, 1'b0, 2'd0, 11'd14, 11'd34, 11'd56, 1'b1};
        tbl[3]  = '{BM, 11'd23, 11'd59, 11'd59, 1'b1, 2'd3, 11'd23, 11'd59, 11'd59, 1'b0};
        tbl[4]  = '{BU, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[5]  = '{BR, 11'd0, 11'd0, 11'd0, 1'b1, 2'd2, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[6]  = '{BR, 11'd0, 11'd0, 11'd0, 1'b1, 2'd1, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[7]  = '{BU, 11'd0, 11'd0, 11'd0, 1'b1, 2'd1, 11'd0, 11'd59, 11'd0, 1'b0};
        tbl[8]  = '{BD, 11'd0, 11'd0, 11'd0, 1'b1, 2'd1, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[9]  = '{BL, 11'd0, 11'd0, 11'd0, 1'b1, 2'd2, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[10] = '{BL, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[11] = '{BL, 11'd0, 11'd0, 11'd0, 1'b1, 2'd1, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[12] = '{BR, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd0, 11'd59, 11'd59, 1'b0};
        tbl[13] = '{BD, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd23, 11'd59, 11'd59, 1'b0};
        tbl[14] = '{BU | BM, 11'd0, 11'd0, 11'd0, 1'b0, 2'd0, 11'd23, 11'd59, 11'd59, 1'b1};
        tbl[15] = '{BM, 11'd30, 11'd75, 11'd60, 1'b1, 2'd3, 11'd0, 11'd0, 11'd0, 1'b0};
        tbl[16] = '{BD, 11'd0, 11'd0, 11'd0, 1'b1, 2'd3, 11'd23, 11'd0, 11'd0, 1'b0};

        // Reset, then idle.
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();
        chk_state("reset", 1'b0, 2'd0, 11'd0, 11'd0, 11'd0);
        chk("reset_load", {31'd0, load}, 32'd0);

        // Press latency: raw middle first sampled at E0, updates land at E(N+3).
        cur_hour = 11'd12; cur_minute = 11'd34; cur_second = 11'd56;
        tick();
        middle = 1'b1;
        repeat (N + 3) tick();
        chk("latency_before", {31'd0, editing}, 32'd0);
        tick();
        chk_state("latency_after", 1'b1, 2'd3, 11'd12, 11'd34, 11'd56);
        repeat (8) tick();
        middle = 1'b0;
        repeat (N + 8) tick();

        // Table of single-press actions.
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].btn[4] && !editing) begin
                cur_hour = tbl[i].ch; cur_minute = tbl[i].cm; cur_second = tbl[i].cs;
            end
            if (tbl[i].commit)
                sb_q.push_back('{h: tbl[i].eh, m: tbl[i].em, s: tbl[i].es});
            press(tbl[i].btn);
            chk_state($sformatf("vec%0d", i), tbl[i].exp_ed, tbl[i].exp_f,
                      tbl[i].eh, tbl[i].em, tbl[i].es);
        end
        chk("loads_after_table", load_cnt, 32'd2);

        // Bounce shorter than the debounce window: no action.
        for (int k = 0; k < 66; k++) begin
            up = ~up;
            repeat (3) tick();
        end
        up = 1'b0;
        repeat (N + 8) tick();
        chk_state("bounce", 1'b1, 2'd3, 11'd23, 11'd0, 11'd0);

        // Long hold: exactly one increment.
        up = 1'b1;
        repeat (500) tick();
        up = 1'b0;
        repeat (N + 8) tick();
        chk_state("hold", 1'b1, 2'd3, 11'd0, 11'd0, 11'd0);

        // Timeout abandons the edit without a load.
        press(BR);
        press(BU);
        chk_state("pre_timeout", 1'b1, 2'd2, 11'd0, 11'd1, 11'd0);
        lc = load_cnt;
        repeat (TMO - 60) tick();
        chk("timeout_early", {31'd0, editing}, 32'd1);
        repeat (60) tick();
        chk_state("timeout", 1'b0, 2'd0, 11'd0, 11'd1, 11'd0);
        chk("timeout_no_load", load_cnt, lc);

        // Reset mid-edit clears everything without a load.
        cur_hour = 11'd5; cur_minute = 11'd6; cur_second = 11'd7;
        press(BM);
        chk_state("reedit", 1'b1, 2'd3, 11'd5, 11'd6, 11'd7);
        rst = 1'b1;
        tick();
        chk_state("mid_reset", 1'b0, 2'd0, 11'd0, 11'd0, 11'd0);
        chk("mid_reset_load", {31'd0, load}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        chk("final_loads", load_cnt, lc);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
